// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        EXC
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR
    } sel_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

    // Redirect priority: register jump, then J-type, then taken branch.
    function automatic sel_t pick_sel(input logic is_jr,
                                      input logic is_jump,
                                      input logic branch_taken);
        if (is_jr)             return SEL_JR;
        else if (is_jump)      return SEL_J;
        else if (branch_taken) return SEL_BR;
        else                   return SEL_SEQ;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/control <-> PC sequencer connection.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic [31:0]       instr;
    logic              branch_taken;
    logic              is_jump;
    logic              is_jr;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect_pending;
    logic              exc_valid;
    logic [ADDR_W-1:0] epc;

    modport master (
        output stall, instr, branch_taken, is_jump, is_jr, jr_target,
        input  pc, pc_plus4, redirect_pending, exc_valid, epc
    );

    modport slave (
        input  stall, instr, branch_taken, is_jump, is_jr, jr_target,
        output pc, pc_plus4, redirect_pending, exc_valid, epc
    );
endinterface

// File: rtl/pc_target_gen.sv
// Combinational next-address arithmetic for the PC sequencer.
module pc_target_gen #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [25:0]       instr,      // opcode field is not needed here
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] br_tgt,
    output logic [ADDR_W-1:0] j_tgt,
    output logic              misaligned
);

    logic [ADDR_W-1:0] br_offset;

    // Sequential, branch and J-type targets; all arithmetic wraps at ADDR_W.
    always_comb begin
        pc_plus4   = pc + ADDR_W'(4);
        br_offset  = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
        br_tgt     = pc_plus4 + br_offset;
        j_tgt      = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
        misaligned = (jr_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register with stall buffering and misaligned-JR exception.
//
// state | meaning
// RUN   | normal fetch, pc advances or redirects when not stalled
// HOLD  | stalled with a redirect buffered in hold_q
// EXC   | one cycle after a misaligned JR; pc sits at the exception vector
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_sequencer_if.slave bus
);

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] hold_q;
    logic [ADDR_W-1:0] epc_q;
    logic              pending_q;
    logic              exc_q;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic              jr_misaligned;
    sel_t              sel;
    logic              redirect;
    logic              misaligned;
    logic [ADDR_W-1:0] next_tgt;

    pc_target_gen #(.ADDR_W(ADDR_W)) u_target_gen (
        .pc         (pc_q),
        .instr      (bus.instr[25:0]),
        .jr_target  (bus.jr_target),
        .pc_plus4   (pc_plus4),
        .br_tgt     (br_tgt),
        .j_tgt      (j_tgt),
        .misaligned (jr_misaligned)
    );

    // Pick the winning target; alignment only matters when JR wins.
    always_comb begin
        sel        = pick_sel(bus.is_jr, bus.is_jump, bus.branch_taken);
        redirect   = (sel != SEL_SEQ);
        misaligned = (sel == SEL_JR) && jr_misaligned;
        case (sel)
            SEL_BR:  next_tgt = br_tgt;
            SEL_J:   next_tgt = j_tgt;
            SEL_JR:  next_tgt = bus.jr_target;
            default: next_tgt = pc_plus4;
        endcase
    end

    // Sequencer FSM with registered pc, epc, pending and exception flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pc_q      <= RESET_PC;
            hold_q    <= '0;
            epc_q     <= '0;
            pending_q <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            exc_q <= 1'b0;
            case (state)
                RUN: begin
                    if (!bus.stall) begin
                        if (misaligned) begin
                            pc_q  <= EXC_VECTOR;
                            epc_q <= pc_q;
                            exc_q <= 1'b1;
                            state <= EXC;
                        end else begin
                            pc_q <= next_tgt;
                        end
                    end else if (redirect && !misaligned) begin
                        // A misaligned JR under stall is re-evaluated once stall drops.
                        hold_q    <= next_tgt;
                        pending_q <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.stall) begin
                        if (redirect && !misaligned) begin
                            hold_q <= next_tgt;
                        end
                    end else begin
                        // Inputs this cycle belong to the held instruction.
                        pc_q      <= hold_q;
                        pending_q <= 1'b0;
                        state     <= RUN;
                    end
                end
                EXC: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_plus4         = pc_plus4;
    assign bus.redirect_pending = pending_q;
    assign bus.exc_valid        = exc_q;
    assign bus.epc              = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall        = 1'b0;
        bus.instr        = 32'h0;
        bus.branch_taken = 1'b0;
        bus.is_jump      = 1'b0;
        bus.is_jr        = 1'b0;
        bus.jr_target    = 32'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_pending", 32'(bus.redirect_pending), 32'h0);
        chk("rst_exc", 32'(bus.exc_valid), 32'h0);
        chk("rst_epc", bus.epc, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        chk("seq0", bus.pc, 32'h0);
        chk("seq0_plus4", bus.pc_plus4, 32'h4);
        tick(); chk("seq1", bus.pc, 32'h4);
        tick(); chk("seq2", bus.pc, 32'h8);
        tick(); chk("seq3", bus.pc, 32'hC);
        chk("seq_exc", 32'(bus.exc_valid), 32'h0);

        // Backward branch: 0x00400014 - 16
        bus.is_jr = 1'b1; bus.jr_target = 32'h0040_0010;
        tick(); idle();
        chk("jr_setup1", bus.pc, 32'h0040_0010);
        bus.branch_taken = 1'b1; bus.instr = 32'h0000_FFFC;
        tick(); idle();
        chk("branch_back", bus.pc, 32'h0040_0004);

        // J-type keeps region bits of pc+4 and beats a taken branch
        bus.is_jr = 1'b1; bus.jr_target = 32'h9000_0000;
        tick(); idle();
        chk("jr_setup2", bus.pc, 32'h9000_0000);
        bus.is_jump = 1'b1; bus.branch_taken = 1'b1; bus.instr = 32'h0010_0000;
        tick(); idle();
        chk("jump_over_br", bus.pc, 32'h9040_0000);

        // JR beats both J and branch
        bus.is_jr = 1'b1; bus.jr_target = 32'h0000_0040;
        bus.is_jump = 1'b1; bus.branch_taken = 1'b1; bus.instr = 32'h0000_0100;
        tick(); idle();
        chk("jr_priority", bus.pc, 32'h0000_0040);

        // Redirect during stall is buffered; inputs on release are ignored
        bus.stall = 1'b1; bus.is_jump = 1'b1; bus.instr = 32'h0000_0400;
        tick();
        chk("stall_pc1", bus.pc, 32'h0000_0040);
        chk("stall_pend1", 32'(bus.redirect_pending), 32'h1);
        tick(); tick();
        chk("stall_pc3", bus.pc, 32'h0000_0040);
        chk("stall_pend3", 32'(bus.redirect_pending), 32'h1);
        bus.stall = 1'b0; bus.instr = 32'h0000_0200;
        tick(); idle();
        chk("release_pc", bus.pc, 32'h0000_1000);
        chk("release_pend", 32'(bus.redirect_pending), 32'h0);

        // Latest redirect during stall wins
        bus.stall = 1'b1; bus.is_jump = 1'b1; bus.instr = 32'h0000_0400;
        tick();
        bus.instr = 32'h0000_0800;
        tick(); idle();
        tick();
        chk("latest_wins", bus.pc, 32'h0000_2000);

        // Misaligned JR takes the exception
        bus.is_jr = 1'b1; bus.jr_target = 32'h0000_0100;
        tick(); idle();
        chk("jr_setup3", bus.pc, 32'h0000_0100);
        bus.is_jr = 1'b1; bus.jr_target = 32'h0000_0202;
        tick(); idle();
        chk("exc_pc", bus.pc, 32'h8000_0180);
        chk("exc_epc", bus.epc, 32'h0000_0100);
        chk("exc_pulse", 32'(bus.exc_valid), 32'h1);
        bus.stall = 1'b1;
        tick(); idle();
        chk("exc_hold_pc", bus.pc, 32'h8000_0180);
        chk("exc_pulse_end", 32'(bus.exc_valid), 32'h0);
        bus.is_jr = 1'b1; bus.jr_target = 32'h0000_0200;
        tick(); idle();
        chk("jr_aligned", bus.pc, 32'h0000_0200);
        chk("jr_aligned_exc", 32'(bus.exc_valid), 32'h0);
        chk("epc_kept", bus.epc, 32'h0000_0100);

        // Misaligned JR while stalled latches nothing, fires on release
        bus.stall = 1'b1; bus.is_jr = 1'b1; bus.jr_target = 32'h0000_0203;
        tick();
        chk("mis_stall_pend", 32'(bus.redirect_pending), 32'h0);
        chk("mis_stall_pc", bus.pc, 32'h0000_0200);
        chk("mis_stall_exc", 32'(bus.exc_valid), 32'h0);
        bus.stall = 1'b0;
        tick(); idle();
        chk("mis_rel_pc", bus.pc, 32'h8000_0180);
        chk("mis_rel_epc", bus.epc, 32'h0000_0200);
        chk("mis_rel_exc", 32'(bus.exc_valid), 32'h1);
        tick();

        // Sequential wrap at the top of the address space
        bus.is_jr = 1'b1; bus.jr_target = 32'hFFFF_FFFC;
        tick(); idle();
        chk("wrap_setup", bus.pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", bus.pc_plus4, 32'h0);
        tick();
        chk("wrap_pc", bus.pc, 32'h0);
        tick();
        chk("wrap_next", bus.pc, 32'h4);

        // Asynchronous reset while in HOLD
        bus.stall = 1'b1; bus.is_jump = 1'b1; bus.instr = 32'h0000_0400;
        tick();
        chk("hold_pend", 32'(bus.redirect_pending), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pc", bus.pc, 32'h0);
        chk("async_pend", 32'(bus.redirect_pending), 32'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_pc", bus.pc, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
